// File: rtl/bcd_scan_counter.sv
// -----------------------------------------------------------------------------
// bcd_scan_counter
//
// N-digit BCD up/down counter with a built-in step prescaler and a
// multiplexed, active-low 7-segment scan driver.
//
// Parameters
//   NDIG      number of BCD digits / anodes (1..8)
//   CNT_DIV   mclk cycles per count step (>=2)
//   SCAN_DIV  mclk cycles each digit stays lit (>=2)
//
// Ports
//   mclk       in   system clock, all logic on posedge
//   rst_n      in   asynchronous reset, active low
//   en         in   count enable, sampled on the step tick
//   up         in   1 = count up, 0 = count down
//   clr        in   synchronous clear of count and step prescaler
//   D0_a       out  anode select, active-low one-hot
//   D0_seg     out  segments {dp,g,f,e,d,c,b,a}, active low
//   count_bcd  out  current count, digit 0 in [3:0]
//   wrap       out  one-cycle pulse when the count wraps over its full range
//
// Build option
//   LEADING_ZERO_BLANK_EN  when defined, digits above the most significant
//                          nonzero digit are blanked (D0_seg=8'hFF) while the
//                          anode keeps cycling; digit 0 is always shown.
//                          count_bcd and wrap are identical in both builds.
// -----------------------------------------------------------------------------
module bcd_scan_counter #(
  parameter int NDIG     = 4,
  parameter int CNT_DIV  = 50000,
  parameter int SCAN_DIV = 50000
) (
  input  logic              mclk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              up,
  input  logic              clr,
  output logic [NDIG-1:0]   D0_a,
  output logic [7:0]        D0_seg,
  output logic [4*NDIG-1:0] count_bcd,
  output logic              wrap
);

  localparam int CW = $clog2(CNT_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(CNT_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CW-1:0]     cpre_q, cpre_d;     // step prescaler
  logic [SW-1:0]     spre_q, spre_d;     // scan prescaler
  logic [IW-1:0]     idx_q, idx_d;       // digit currently selected
  logic [4*NDIG-1:0] count_q, count_d;
  logic              wrap_q, wrap_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic [7:0]        seg_q, seg_d;

  logic              step_tick;
  logic              scan_tick;
  logic [4*NDIG:0]   inc_res;            // {carry_out, incremented count}
  logic [4*NDIG:0]   dec_res;            // {borrow_out, decremented count}
  logic [NDIG-1:0]   blank;              // per-digit leading-zero blanking
  logic [3:0]        digit_sel;
  logic              blank_sel;

  // ---------------------------------------------------------------------------
  // BCD arithmetic helpers. The carry/borrow out of the top digit is exactly
  // the full-range wrap condition (all 9s going up, all 0s going down).
  // ---------------------------------------------------------------------------
  function automatic logic [4*NDIG:0] bcd_inc(input logic [4*NDIG-1:0] v);
    logic [4*NDIG-1:0] r;
    logic              c;
    logic [3:0]        d;
    r = v;
    c = 1'b1;
    for (int k = 0; k < NDIG; k++) begin
      d = v[4*k +: 4];
      if (c) begin
        if (d >= 4'd9) begin
          r[4*k +: 4] = 4'd0;
        end else begin
          r[4*k +: 4] = d + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  function automatic logic [4*NDIG:0] bcd_dec(input logic [4*NDIG-1:0] v);
    logic [4*NDIG-1:0] r;
    logic              b;
    logic [3:0]        d;
    r = v;
    b = 1'b1;
    for (int k = 0; k < NDIG; k++) begin
      d = v[4*k +: 4];
      if (b) begin
        if (d == 4'd0) begin
          r[4*k +: 4] = 4'd9;
        end else if (d > 4'd9) begin
          // Unreachable from reset; forces any corrupted digit back into range.
          r[4*k +: 4] = 4'd9;
          b = 1'b0;
        end else begin
          r[4*k +: 4] = d - 4'd1;
          b = 1'b0;
        end
      end
    end
    return {b, r};
  endfunction

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Step prescaler and counter
  // ---------------------------------------------------------------------------
  assign step_tick = (cpre_q == CNT_LAST);

  always_comb begin
    inc_res = bcd_inc(count_q);
    dec_res = bcd_dec(count_q);
    cpre_d  = step_tick ? '0 : cpre_q + 1'b1;
    count_d = count_q;
    wrap_d  = 1'b0;
    // clr has priority over a coincident step tick.
    if (clr) begin
      cpre_d  = '0;
      count_d = '0;
    end else if (step_tick && en) begin
      if (up) begin
        {wrap_d, count_d} = inc_res;
      end else begin
        {wrap_d, count_d} = dec_res;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero blanking mask
  // ---------------------------------------------------------------------------
`ifdef LEADING_ZERO_BLANK_EN
  logic nz_above;

  // Walk down from the top digit: a digit is blanked while every digit from
  // it upward is zero. Digit 0 is never blanked.
  always_comb begin
    blank    = '0;
    nz_above = 1'b0;
    for (int k = NDIG - 1; k >= 1; k--) begin
      if (count_q[4*k +: 4] != 4'd0) begin
        nz_above = 1'b1;
      end
      blank[k] = ~nz_above;
    end
  end
`else
  assign blank = '0;
`endif

  // ---------------------------------------------------------------------------
  // Scan prescaler and digit index
  // ---------------------------------------------------------------------------
  assign scan_tick = (spre_q == SCAN_LAST);

  always_comb begin
    spre_d = scan_tick ? '0 : spre_q + 1'b1;
    idx_d  = idx_q;
    if (scan_tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Select the digit about to be shown. A compare loop keeps a
  // non-power-of-two NDIG from ever indexing past the last digit.
  always_comb begin
    digit_sel = 4'd0;
    blank_sel = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      if (IW'(k) == idx_d) begin
        digit_sel = count_q[4*k +: 4];
        blank_sel = blank[k];
      end
    end
  end

  // Anode and segments are loaded together on the selecting edge, so they
  // never disagree; the count is sampled only then and held for the slot.
  always_comb begin
    an_d  = an_q;
    seg_d = seg_q;
    if (scan_tick) begin
      an_d  = ~(NDIG'(1) << idx_d);
      seg_d = blank_sel ? 8'hFF : seg_code(digit_sel);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      cpre_q  <= '0;
      spre_q  <= '0;
      idx_q   <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
      an_q    <= '1;
      seg_q   <= 8'hFF;
    end else begin
      cpre_q  <= cpre_d;
      spre_q  <= spre_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign D0_a      = an_q;
  assign D0_seg    = seg_q;
  assign count_bcd = count_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_scan_counter
//
// Drives bcd_scan_counter (NDIG=4, CNT_DIV=4, SCAN_DIV=2). A decimal model of
// the count produces expected {wrap, count} values which are queued when a
// step is driven and popped when the step edge has happened. Scan checks
// queue the expected {anode, segment} sequence and pop one entry per cycle.
// -----------------------------------------------------------------------------
module tb_bcd_scan_counter;

  localparam int NDIG     = 4;
  localparam int CNT_DIV  = 4;
  localparam int SCAN_DIV = 2;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [7:0] ZSEG = 8'hFF;
`else
  localparam logic [7:0] ZSEG = 8'hC0;
`endif

  logic              mclk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              up;
  logic              clr;
  logic [NDIG-1:0]   D0_a;
  logic [7:0]        D0_seg;
  logic [4*NDIG-1:0] count_bcd;
  logic              wrap;

  logic [16:0] exp_q[$];   // {wrap, count}
  logic [11:0] scan_q[$];  // {anode, segments}

  int checks    = 0;
  int errors    = 0;
  int model_val = 0;

  bcd_scan_counter #(
    .NDIG     (NDIG),
    .CNT_DIV  (CNT_DIV),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .mclk      (mclk),
    .rst_n     (rst_n),
    .en        (en),
    .up        (up),
    .clr       (clr),
    .D0_a      (D0_a),
    .D0_seg    (D0_seg),
    .count_bcd (count_bcd),
    .wrap      (wrap)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  always #5 mclk = ~mclk;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int p;
    p = 1;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // One full step period from a prescaler-aligned negedge. The three
  // non-tick cycles must show the old count with wrap low; the tick edge
  // result is popped from the scoreboard.
  task automatic tick(input logic t_en, input logic t_up);
    logic        w;
    logic [15:0] prev;
    logic [16:0] e;
    prev = to_bcd(model_val);
    w    = 1'b0;
    en   = t_en;
    up   = t_up;
    if (t_en) begin
      if (t_up) begin
        w = (model_val == 9999);
        model_val = (model_val + 1) % 10000;
      end else begin
        w = (model_val == 0);
        model_val = (model_val + 9999) % 10000;
      end
    end
    exp_q.push_back({w, to_bcd(model_val)});
    for (int c = 0; c < CNT_DIV - 1; c++) begin
      @(posedge mclk);
      @(negedge mclk);
      checks++;
      if (count_bcd !== prev || wrap !== 1'b0) begin
        errors++;
        $display("FAIL hold: count %h wrap %b, required count %h wrap 0",
                 count_bcd, wrap, prev);
      end
    end
    @(posedge mclk);
    @(negedge mclk);
    e = exp_q.pop_front();
    checks++;
    if ({wrap, count_bcd} !== e) begin
      errors++;
      $display("FAIL step: count %h wrap %b, required count %h wrap %b",
               count_bcd, wrap, e[15:0], e[16]);
    end
  endtask

  task automatic do_clear();
    clr = 1'b1;
    @(posedge mclk);
    @(negedge mclk);
    clr = 1'b0;
    model_val = 0;
    checks++;
    if (count_bcd !== 16'h0000 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL clear: count %h wrap %b, required count 0000 wrap 0",
               count_bcd, wrap);
    end
  endtask

  // Wait for anode E to be newly selected, then compare nine cycles of
  // {anode, segments}. Pads to a whole step period so later ticks stay aligned.
  task automatic check_scan(input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3);
    logic [NDIG-1:0] prev_an;
    logic [11:0]     e;
    int              used;
    bit              found;
    en = 1'b0;
    for (int r = 0; r < 2; r++) scan_q.push_back({4'hE, s0});
    for (int r = 0; r < 2; r++) scan_q.push_back({4'hD, s1});
    for (int r = 0; r < 2; r++) scan_q.push_back({4'hB, s2});
    for (int r = 0; r < 2; r++) scan_q.push_back({4'h7, s3});
    scan_q.push_back({4'hE, s0});
    prev_an = D0_a;
    found   = 1'b0;
    used    = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge mclk);
      @(negedge mclk);
      used++;
      if (D0_a === 4'hE && prev_an !== 4'hE) found = 1'b1;
      prev_an = D0_a;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL scan_timeout: anode %h, required a new select of E", D0_a);
      scan_q.delete();
    end else begin
      while (scan_q.size() > 0) begin
        e = scan_q.pop_front();
        checks++;
        if ({D0_a, D0_seg} !== e) begin
          errors++;
          $display("FAIL scan: anode %h seg %h, required anode %h seg %h",
                   D0_a, D0_seg, e[11:8], e[7:0]);
        end
        if (scan_q.size() > 0) begin
          @(posedge mclk);
          @(negedge mclk);
          used++;
        end
      end
    end
    while (used % CNT_DIV != 0) begin
      @(posedge mclk);
      @(negedge mclk);
      used++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    up    = 1'b1;
    clr   = 1'b0;
    repeat (3) @(posedge mclk);
    @(negedge mclk);
    checks++;
    if (count_bcd !== 16'h0 || D0_a !== 4'hF || D0_seg !== 8'hFF || wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals: count %h an %h seg %h wrap %b, required 0000 F FF 0",
               count_bcd, D0_a, D0_seg, wrap);
    end
    rst_n     = 1'b1;
    model_val = 0;
    tick(1'b1, 1'b1);
    repeat (5) tick(1'b1, 1'b1);
    // Mid-run reset must act without a clock edge.
    rst_n = 1'b0;
    #1;
    checks++;
    if (count_bcd !== 16'h0 || D0_a !== 4'hF || D0_seg !== 8'hFF || wrap !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: count %h an %h seg %h wrap %b, required 0000 F FF 0",
               count_bcd, D0_a, D0_seg, wrap);
    end
    @(posedge mclk);
    @(negedge mclk);
    rst_n     = 1'b1;
    model_val = 0;
    tick(1'b1, 1'b1);
  endtask

  task automatic test_up_carry();
    do_clear();
    repeat (99) tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);              // 0099 -> 0100
  endtask

  task automatic test_down_borrow();
    tick(1'b1, 1'b0);              // 0100 -> 0099
    do_clear();
    tick(1'b1, 1'b0);              // 0000 -> 9999, wrap
    tick(1'b1, 1'b1);              // 9999 -> 0000, wrap
    tick(1'b1, 1'b1);              // wrap must have dropped after one cycle
  endtask

  task automatic test_clear();
    logic [15:0] prev;
    logic [16:0] e;
    do_clear();
    repeat (42) tick(1'b1, 1'b1);
    en   = 1'b1;
    up   = 1'b1;
    prev = to_bcd(model_val);
    exp_q.push_back({1'b0, 16'h0000});
    for (int c = 0; c < CNT_DIV - 1; c++) begin
      @(posedge mclk);
      @(negedge mclk);
      checks++;
      if (count_bcd !== prev) begin
        errors++;
        $display("FAIL clr_pre: count %h, required %h", count_bcd, prev);
      end
    end
    clr = 1'b1;                    // coincides with the step tick edge
    @(posedge mclk);
    @(negedge mclk);
    clr = 1'b0;
    model_val = 0;
    e = exp_q.pop_front();
    checks++;
    if ({wrap, count_bcd} !== e) begin
      errors++;
      $display("FAIL clr_tick: count %h wrap %b, required count %h wrap %b",
               count_bcd, wrap, e[15:0], e[16]);
    end
    tick(1'b1, 1'b1);              // prescaler restarted: first step after 4
    repeat (20) tick(1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic test_scan();
    do_clear();
    repeat (1234) tick(1'b1, 1'b1);
    check_scan(8'h99, 8'hB0, 8'hA4, 8'hF9);
    repeat (665) tick(1'b1, 1'b0); // 0569
    check_scan(8'h90, 8'h82, 8'h92, ZSEG);
    repeat (20) tick(1'b1, 1'b1);  // 0589
    check_scan(8'h90, 8'h80, 8'h92, ZSEG);
  endtask

  task automatic test_leading_zero();
    do_clear();
    repeat (7) tick(1'b1, 1'b1);
    check_scan(8'hF8, ZSEG, ZSEG, ZSEG);
  endtask

  initial begin
    test_reset();
    test_up_carry();
    test_down_borrow();
    test_clear();
    test_scan();
    test_leading_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
